dmem_ctrl: RTL

Data-memory responder that serves the CPU core's data port (`data_addr`, `read_m`, `write_m`, `out_m`, `in_m`, `stall`). It sits between the core and a request/acknowledge memory bus of arbitrary latency. It posts writes into a small write FIFO and services reads with stall cycles. It also decodes two memory-mapped I/O locations: switches and LEDs.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/wr_fifo.sv | 51 +++++
 rtl/dmem_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// dmem_pkg: shared types and default I/O addresses for the data-memory controller (rev 1.0)
package dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WR    = 2'd1,
    S_RD    = 2'd2,
    S_RHOLD = 2'd3
  } state_t;

  localparam logic [14:0] SW_ADDR_DEF  = 15'h6000;
  localparam logic [14:0] LED_ADDR_DEF = 15'h6001;

  typedef struct packed {
    logic [14:0] addr;
    logic [15:0] data;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wr_fifo.sv
`default_nettype none
// wr_fifo: posted-write FIFO; pointers carry an extra wrap bit to tell full from empty (rev 1.0)
module wr_fifo
  import dmem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     push,
  input  logic                     pop,
  input  wb_entry_t                din,
  output wb_entry_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  wb_entry_t   mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// dmem_ctrl: core data-port responder with posted writes, stalled reads and switch/LED I/O (rev 1.0)
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int          WB_DEPTH = 2,
  parameter logic [14:0] SW_ADDR  = SW_ADDR_DEF,
  parameter logic [14:0] LED_ADDR = LED_ADDR_DEF
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [14:0] data_addr,
  input  logic        read_m,
  input  logic        write_m,
  input  logic [15:0] out_m,
  output logic [15:0] in_m,
  output logic        stall,
  input  logic [3:0]  SW,
  output logic [3:0]  led,
  output logic        mem_req,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int CW = $clog2(WB_DEPTH) + 1;

  state_t      state;
  logic [14:0] rd_addr;
  logic [15:0] rd_data;
  logic [3:0]  sw_meta;
  logic [3:0]  sw_sync;

  logic        is_sw;
  logic        is_led;
  logic        io_addr;
  logic        hit;
  logic        read_miss;
  logic        push;
  logic        pop;
  logic        more_wr;
  wb_entry_t   fifo_din;
  wb_entry_t   fifo_head;
  logic        fifo_full;
  logic        fifo_empty;
  logic [CW-1:0] fifo_count;

  assign is_sw    = (data_addr == SW_ADDR);
  assign is_led   = (data_addr == LED_ADDR);
  assign io_addr  = is_sw || is_led;
  // Held data is only trusted while no younger write is queued behind it.
  assign hit      = (state == S_RHOLD) && read_m && !io_addr &&
                    (data_addr == rd_addr) && fifo_empty;
  assign read_miss = read_m && !io_addr && !hit;
  assign stall    = read_miss || fifo_full;

  assign push     = write_m && !io_addr;
  assign pop      = (state == S_WR) && mem_req && mem_ack;
  assign more_wr  = (fifo_count > CW'(1)) || push;
  assign fifo_din = '{addr: data_addr, data: out_m};

  wr_fifo #(
    .DEPTH (WB_DEPTH)
  ) u_wr_fifo (
    .clk    (clk),
    .resetN (resetN),
    .push   (push),
    .pop    (pop),
    .din    (fifo_din),
    .head   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_comb begin
    in_m = 16'h0000;
    if (read_m) begin
      if (is_sw)       in_m = {12'b0, sw_sync};
      else if (is_led) in_m = {12'b0, led};
      else if (hit)    in_m = rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      sw_meta <= '0;
      sw_sync <= '0;
      led     <= '0;
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;
      if (write_m && is_led) led <= out_m[3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state     <= S_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_addr   <= '0;
      rd_data   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            state     <= S_WR;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= fifo_head.addr;
            mem_wdata <= fifo_head.data;
          end else if (push) begin
            // Launch straight from the incoming write so the request rises next cycle.
            state     <= S_WR;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= data_addr;
            mem_wdata <= out_m;
          end else if (read_miss) begin
            state    <= S_RD;
            rd_addr  <= data_addr;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= data_addr;
          end
        end
        S_WR: begin
          if (!mem_req) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= fifo_head.addr;
            mem_wdata <= fifo_head.data;
          end else if (mem_ack) begin
            // Drop the request for a cycle; the next head is reloaded from the FIFO.
            mem_req <= 1'b0;
            if (!more_wr) begin
              if (read_miss) begin
                state    <= S_RD;
                rd_addr  <= data_addr;
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= data_addr;
              end else begin
                state <= S_IDLE;
              end
            end
          end
        end
        S_RD: begin
          if (mem_ack) begin
            rd_data <= mem_rdata;
            mem_req <= 1'b0;
            state   <= S_RHOLD;
          end
        end
        S_RHOLD: begin
          state <= (push || !fifo_empty) ? S_WR : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
